// File: rtl/sync_fifo_pkg.sv
// Shared defaults for the synchronous FIFO and its storage array.
package sync_fifo_pkg;
  localparam int DATA_WIDTH = 8;
  localparam int DEPTH      = 16;
  localparam int ADDR_WIDTH = $clog2(DEPTH);
endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write port, combinational addressed read port, no reset.
module fifo_mem
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = sync_fifo_pkg::DATA_WIDTH,
  parameter int DEPTH      = sync_fifo_pkg::DEPTH,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [ADDR_WIDTH-1:0] i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic [ADDR_WIDTH-1:0] i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Synchronous FIFO: wrap-bit pointers, flags decoded from registered pointers, registered dout.
module sync_fifo
  import sync_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = sync_fifo_pkg::DATA_WIDTH,
  parameter int DEPTH      = sync_fifo_pkg::DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  logic [AW:0]           r_wr_ptr;
  logic [AW:0]           r_rd_ptr;
  logic [DATA_WIDTH-1:0] r_dout;
  logic                  w_wr_en;
  logic                  w_rd_en;
  logic [DATA_WIDTH-1:0] w_rdata;

  // Request semantics: wr is accepted only while !full, rd only while !empty;
  // a rejected request has no side effect and there is no error indication.
  assign w_wr_en = wr & ~full;
  assign w_rd_en = rd & ~empty;

  // Flags depend only on pointer registers, never on wr/rd/din.
  assign empty = (r_wr_ptr == r_rd_ptr);
  assign full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) &&
                 (r_wr_ptr[AW] != r_rd_ptr[AW]);
  assign dout  = r_dout;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_wr_en & ~reset),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (din),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_dout   <= '0;
    end else begin
      if (w_wr_en) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_rd_en) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
        r_dout   <= w_rdata;
      end
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo (DATA_WIDTH=8, DEPTH=16).
module tb_sync_fifo;

  logic       clk;
  logic       reset;
  logic       wr;
  logic       rd;
  logic [7:0] din;
  logic [7:0] dout;
  logic       full;
  logic       empty;

  int n_checks;
  int n_errors;
  logic [7:0] exp_q[$];

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk   (clk),
    .reset (reset),
    .wr    (wr),
    .rd    (rd),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, wanted finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, wanted 0x%0h", tag, got, exp);
    end
  endtask

  // driver: apply inputs for one edge, then sample 1 time unit after it
  task automatic do_cycle(input logic w, input logic r, input logic [7:0] d);
    wr  = w;
    rd  = r;
    din = d;
    @(posedge clk);
    #1;
    wr  = 1'b0;
    rd  = 1'b0;
  endtask

  task automatic check_flags(input string tag, input logic e_empty, input logic e_full);
    check_eq({tag, "_empty"}, {31'b0, empty}, {31'b0, e_empty});
    check_eq({tag, "_full"},  {31'b0, full},  {31'b0, e_full});
  endtask

  logic [7:0] exp_d;

  initial begin
    n_checks = 0;
    n_errors = 0;
    wr = 1'b0; rd = 1'b0; din = 8'h00; reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;

    // reset then idle
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b0, 1'b0, 8'h00);
      check_flags("idle", 1'b1, 1'b0);
      check_eq("idle_dout", {24'b0, dout}, 32'h00);
    end

    // three writes then three reads
    do_cycle(1'b1, 1'b0, 8'h11);
    check_flags("wr1", 1'b0, 1'b0);
    do_cycle(1'b1, 1'b0, 8'h22);
    do_cycle(1'b1, 1'b0, 8'h33);
    check_eq("wr3_dout_hold", {24'b0, dout}, 32'h00);
    do_cycle(1'b0, 1'b1, 8'h00);
    check_eq("rd1", {24'b0, dout}, 32'h11);
    do_cycle(1'b0, 1'b1, 8'h00);
    check_eq("rd2", {24'b0, dout}, 32'h22);
    do_cycle(1'b0, 1'b1, 8'h00);
    check_eq("rd3", {24'b0, dout}, 32'h33);
    check_flags("after_rd3", 1'b1, 1'b0);
    do_cycle(1'b0, 1'b0, 8'h00);
    check_eq("hold_no_rd", {24'b0, dout}, 32'h33);

    // fill to full, overflow write ignored, drain in order
    for (int i = 0; i < 16; i++) begin
      do_cycle(1'b1, 1'b0, 8'(i));
      if (i == 14) check_flags("fill15", 1'b0, 1'b0);
    end
    check_flags("fill16", 1'b0, 1'b1);
    do_cycle(1'b1, 1'b0, 8'hAA);
    check_flags("overflow", 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      do_cycle(1'b0, 1'b1, 8'h00);
      check_eq("drain", {24'b0, dout}, 32'(i));
      if (i == 0) check_flags("drain1", 1'b0, 1'b0);
    end
    check_flags("drained", 1'b1, 1'b0);

    // read at empty, then simultaneous wr/rd at empty
    do_cycle(1'b0, 1'b1, 8'h00);
    check_eq("rd_empty_hold", {24'b0, dout}, 32'h0F);
    check_flags("rd_empty", 1'b1, 1'b0);
    do_cycle(1'b1, 1'b1, 8'h44);
    check_eq("wrrd_empty_dout", {24'b0, dout}, 32'h0F);
    check_flags("wrrd_empty", 1'b0, 1'b0);
    do_cycle(1'b0, 1'b1, 8'h00);
    check_eq("rd_44", {24'b0, dout}, 32'h44);
    check_flags("after_44", 1'b1, 1'b0);

    // simultaneous wr/rd at full: only the read is accepted
    for (int i = 0; i < 16; i++) do_cycle(1'b1, 1'b0, 8'h80 + 8'(i));
    check_flags("full2", 1'b0, 1'b1);
    do_cycle(1'b1, 1'b1, 8'hAA);
    check_eq("wrrd_full_dout", {24'b0, dout}, 32'h80);
    check_flags("wrrd_full", 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) begin
      do_cycle(1'b0, 1'b1, 8'h00);
      check_eq("drain2", {24'b0, dout}, 32'h80 + 32'(i));
    end
    check_flags("drained2", 1'b1, 1'b0);

    // occupancy 5, 30 cycles of concurrent wr/rd across pointer wrap
    for (int i = 0; i < 5; i++) begin
      do_cycle(1'b1, 1'b0, 8'h50 + 8'(i));
      exp_q.push_back(8'h50 + 8'(i));
    end
    for (int i = 0; i < 30; i++) begin
      do_cycle(1'b1, 1'b1, 8'hC0 + 8'(i));
      exp_q.push_back(8'hC0 + 8'(i));
      exp_d = exp_q.pop_front();
      check_eq("steady", {24'b0, dout}, {24'b0, exp_d});
      check_flags("steady", 1'b0, 1'b0);
    end
    while (exp_q.size() > 0) begin
      do_cycle(1'b0, 1'b1, 8'h00);
      exp_d = exp_q.pop_front();
      check_eq("steady_drain", {24'b0, dout}, {24'b0, exp_d});
    end
    check_flags("steady_done", 1'b1, 1'b0);

    // reset mid-operation, with concurrent requests that must be discarded
    for (int i = 0; i < 4; i++) do_cycle(1'b1, 1'b0, 8'h71 + 8'(i));
    check_flags("pre_reset", 1'b0, 1'b0);
    reset = 1'b1;
    do_cycle(1'b1, 1'b1, 8'h99);
    reset = 1'b0;
    check_flags("post_reset", 1'b1, 1'b0);
    check_eq("post_reset_dout", {24'b0, dout}, 32'h00);
    do_cycle(1'b0, 1'b1, 8'h00);
    check_eq("rd_after_reset", {24'b0, dout}, 32'h00);
    check_flags("rd_after_reset", 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo.md
SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The module SHALL have parameter DATA_WIDTH, default 8, the data word width in bits.
REQ-002 The module SHALL have parameter DEPTH, default 16, the number of storage entries; it SHALL be a power of two of at least 2.
REQ-003 The module SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit, synchronous active-high reset.
REQ-005 The module SHALL have port wr, input, 1 bit, the write request.
REQ-006 The module SHALL have port rd, input, 1 bit, the read request.
REQ-007 The module SHALL have port din, input, DATA_WIDTH bits, the write data.
REQ-008 The module SHALL have port dout, output, DATA_WIDTH bits, the registered read data.
REQ-009 The module SHALL have port full, output, 1 bit, high when DEPTH entries are stored.
REQ-010 The module SHALL have port empty, output, 1 bit, high when 0 entries are stored.

Function
REQ-011 The FIFO SHALL perform an accepted write when wr=1 and full=0 at a rising clk edge; din is stored at the write pointer and the write pointer increments.
REQ-012 The FIFO SHALL ignore a write when wr=1 and full=1; storage, pointers and flags remain unchanged, with no error output.
REQ-013 The FIFO SHALL perform an accepted read when rd=1 and empty=0 at a rising clk edge; the entry at the read pointer is registered onto dout at that edge, giving 1-cycle latency, and the read pointer increments.
REQ-014 The FIFO SHALL ignore a read when rd=1 and empty=1; dout holds its previous value.
REQ-015 dout SHALL hold its last value in every cycle without an accepted read.
REQ-016 When wr=1 and rd=1 with 0 < occupancy < DEPTH, the FIFO SHALL accept both in the same edge; occupancy is unchanged and the flags are unchanged.
REQ-017 When wr=1 and rd=1 while empty, the FIFO SHALL accept only the write; dout is unchanged and empty deasserts next cycle.
REQ-018 When wr=1 and rd=1 while full, the FIFO SHALL accept only the read; full deasserts next cycle.
REQ-019 Read and write pointers SHALL each be log2(DEPTH)+1 bits, the extra MSB being a wrap bit; addresses wrap from DEPTH-1 to 0.
REQ-020 empty SHALL be 1 when the read and write pointers are equal, including the wrap bit.
REQ-021 full SHALL be 1 when the pointer addresses are equal and the wrap bits differ.
REQ-022 full and empty SHALL be registered-state derived, free of combinational paths from wr, rd or din, and SHALL never both be 1.
REQ-023 Data SHALL be output in strict write order with no loss or duplication across any number of pointer wraps.

Reset
REQ-024 reset=1 at a rising clk edge SHALL set both pointers to 0, dout to 0, empty to 1 and full to 0.
REQ-025 reset SHALL take priority over concurrent wr and rd; requests in a reset cycle are discarded.
REQ-026 Reset mid-operation SHALL discard all stored entries; storage array contents need not be cleared.
REQ-027 Before the first reset, outputs SHALL be treated as undefined; benches must assert reset for at least 1 cycle.

Structure
REQ-028 A package sync_fifo_pkg SHALL hold the DATA_WIDTH and DEPTH defaults and the derived ADDR_WIDTH = $clog2(DEPTH).
REQ-029 Storage SHALL be a sub-module fifo_mem: a simple dual-port array with a synchronous write port and an addressed read port, holding no reset logic.
REQ-030 Pointer and flag control SHALL reside in sync_fifo itself.

Verification
REQ-031 Reset then idle -> empty=1, full=0, dout=0 for 5 cycles.
REQ-032 Write 0x11, 0x22, 0x33, then read 3 times -> dout=0x11, 0x22, 0x33, each 1 cycle after its read edge; empty=1 afterwards.
REQ-033 Write 16 values 0..15 -> full=1 after the 16th edge; a 17th write of 0xAA is ignored; 16 reads return 0..15, then empty=1.
REQ-034 Read when empty -> dout holds the last value and pointers do not move; simultaneous wr=1/rd=1 at empty -> only the write is accepted, empty=0 next cycle.
REQ-035 Fill 16, then simultaneous wr/rd -> only the read is accepted and full=0; at occupancy 5, 30 cycles of simultaneous wr/rd hold occupancy at 5 and preserve order across wrap.
REQ-036 Write 4 entries, assert reset for 1 cycle -> empty=1, dout=0, and a subsequent read returns nothing new.
